// File: rtl/counter_checker.sv
// ============================================================================
// counter_checker
//
// Sink-side checker for a free-running counter stream. Each valid sample is
// compared against a prediction of "previous value + 1" (mod 2^WIDTH). The
// checker acquires lock after LOCK_COUNT contiguous samples. Once locked it
// flywheels: isolated mismatches are counted and pulsed, but the prediction
// keeps advancing by one rather than resyncing to the bad sample. UNLOCK_COUNT
// back-to-back mismatches drop lock and restart acquisition.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   in_valid      in_data carries a sample this cycle
//   in_data       sampled counter value
//   clear_errors  synchronous clear of error_count
//   locked        high while LOCKED or SLIPPING
//   error_pulse   one-cycle pulse per mismatch seen while locked
//   expected      predicted value of the next valid sample
//   error_count   saturating mismatch count
// ============================================================================
module counter_checker #(
    parameter int WIDTH         = 8,
    parameter int LOCK_COUNT    = 4,
    parameter int UNLOCK_COUNT  = 2,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     clear_errors,
    output logic                     locked,
    output logic                     error_pulse,
    output logic [WIDTH-1:0]         expected,
    output logic [ERR_CNT_WIDTH-1:0] error_count
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_COUNT + 1);

    // Counter values at which the *current* sample completes the run, so the
    // transitions can be decided without a wider "+1" compare.
    localparam logic [GOOD_W-1:0] LOCK_LAST   = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [BAD_W-1:0]  UNLOCK_LAST = BAD_W'(UNLOCK_COUNT - 1);

    typedef enum logic [1:0] {
        SEARCH   = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2,
        SLIPPING = 2'd3
    } state_t;

    state_t              state, state_nx;
    logic [WIDTH-1:0]    expected_nx;
    logic [GOOD_W-1:0]   good_cnt, good_nx;
    logic [BAD_W-1:0]    bad_cnt, bad_nx;
    logic                err_nx;
    logic                match;

    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(
        input logic [ERR_CNT_WIDTH-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

    assign match = (in_data == expected);

    always_comb begin
        state_nx    = state;
        expected_nx = expected;
        good_nx     = good_cnt;
        bad_nx      = bad_cnt;
        err_nx      = 1'b0;
        if (in_valid) begin
            unique case (state)
                SEARCH: begin
                    expected_nx = in_data + 1'b1;
                    good_nx     = GOOD_W'(1);
                    state_nx    = LOCKING;
                end
                LOCKING: begin
                    // Both outcomes follow the incoming data; a mismatch just
                    // restarts the run from this sample.
                    expected_nx = in_data + 1'b1;
                    if (match) begin
                        good_nx = good_cnt + 1'b1;
                        if (good_cnt == LOCK_LAST) begin
                            state_nx = LOCKED;
                            bad_nx   = '0;
                        end
                    end else begin
                        good_nx = GOOD_W'(1);
                    end
                end
                LOCKED: begin
                    // Flywheel: prediction advances regardless of the sample.
                    expected_nx = expected + 1'b1;
                    if (!match) begin
                        err_nx = 1'b1;
                        bad_nx = BAD_W'(1);
                        if (UNLOCK_COUNT == 1) begin
                            state_nx = SEARCH;
                            good_nx  = '0;
                            bad_nx   = '0;
                        end else begin
                            state_nx = SLIPPING;
                        end
                    end
                end
                SLIPPING: begin
                    expected_nx = expected + 1'b1;
                    if (match) begin
                        bad_nx   = '0;
                        state_nx = LOCKED;
                    end else begin
                        err_nx = 1'b1;
                        bad_nx = bad_cnt + 1'b1;
                        if (bad_cnt == UNLOCK_LAST) begin
                            state_nx = SEARCH;
                            good_nx  = '0;
                            bad_nx   = '0;
                        end
                    end
                end
                default: state_nx = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SEARCH;
            expected    <= '0;
            good_cnt    <= '0;
            bad_cnt     <= '0;
            locked      <= 1'b0;
            error_pulse <= 1'b0;
            error_count <= '0;
        end else begin
            state       <= state_nx;
            expected    <= expected_nx;
            good_cnt    <= good_nx;
            bad_cnt     <= bad_nx;
            locked      <= (state_nx == LOCKED) || (state_nx == SLIPPING);
            error_pulse <= err_nx;
            // A clear coinciding with a new error leaves that error counted.
            if (clear_errors)
                error_count <= {{(ERR_CNT_WIDTH-1){1'b0}}, err_nx};
            else if (err_nx)
                error_count <= sat_inc(error_count);
        end
    end

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Receive-side companion to the free-running 8-bit counter source: consumes a sampled counter stream and checks that each valid sample equals the previous sample plus one, modulo 2^WIDTH.
- Acquires lock on a run of contiguous values, then flywheels, meaning it keeps predicting the next value through isolated errors.
- Reports lock status and an error pulse, and keeps a saturating error count.
- Sits at the sink end of any link carrying counter values; used for link integrity checks and bring-up.

Parameters:
- WIDTH, 8, sample/counter width in bits.
- LOCK_COUNT, 4, consecutive contiguous samples needed to declare lock (legal range >= 2).
- UNLOCK_COUNT, 2, consecutive mismatches while locked that drop lock (legal range >= 1).
- ERR_CNT_WIDTH, 16, width of the error counter.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is a sample this cycle.
- in_data  input  WIDTH  sampled counter value.
- clear_errors  input  1  synchronous clear of error_count.
- locked  output  1  high in LOCKED and SLIPPING.
- error_pulse  output  1  one-cycle pulse per mismatch counted while locked.
- expected  output  WIDTH  predicted value of the next valid sample.
- error_count  output  ERR_CNT_WIDTH  saturating count of mismatches.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- All outputs are registered. A sample is evaluated at the rising edge where in_valid=1, and results are visible in the following cycle (latency 1).
- Reset: takes effect immediately with no clock. state=SEARCH, expected=0, good_cnt=0, bad_cnt=0, locked=0, error_pulse=0, error_count=0. Deasserting rst mid-stream restarts acquisition from SEARCH.
- A match means in_data == expected. All next-value arithmetic is in_data+1 or expected+1, truncated to WIDTH bits, so the wrap 2^WIDTH-1 -> 0 counts as a match.
- in_valid=0: all state, counters and expected are held, and error_pulse=0.
- States are SEARCH, LOCKING, LOCKED and SLIPPING.
- SEARCH, on valid: expected <= in_data+1, good_cnt <= 1, go to LOCKING.
- LOCKING, on valid match: expected <= in_data+1, good_cnt++. When good_cnt+1 == LOCK_COUNT, go to LOCKED.
- LOCKING, on valid mismatch: resync with expected <= in_data+1, good_cnt <= 1, stay in LOCKING.
- LOCKING: no errors are counted or pulsed.
- LOCKED, on valid match: expected <= expected+1.
- LOCKED, on valid mismatch:
  - error_pulse=1 next cycle, error_count++, expected <= expected+1 (flywheel, no resync), bad_cnt <= 1.
  - Go to SEARCH if UNLOCK_COUNT==1, otherwise go to SLIPPING.
- SLIPPING, on valid match: bad_cnt <= 0, expected+1, go to LOCKED.
- SLIPPING, on valid mismatch:
  - error pulse, error_count++, expected+1, bad_cnt++.
  - When bad_cnt+1 == UNLOCK_COUNT, go to SEARCH.
- locked deasserts in the cycle after the mismatch that enters SEARCH.
- error_count saturates at all-ones; further errors still pulse error_pulse.
- clear_errors=1 zeroes error_count at the edge. If an error is counted at the same edge, error_count becomes 1.
- clear_errors does not affect state, lock or expected.
- Re-entering SEARCH from loss of lock: the next valid sample seeds a new acquisition, and a full LOCK_COUNT run is needed to relock.

Test Plan:
- Defaults (WIDTH=8, LOCK_COUNT=4, UNLOCK_COUNT=2). Reset, then valid 10,11,12,13 on consecutive cycles -> locked=1 in the cycle after 13 is sampled; expected=14; error_count=0. Feed 10,11,50,51,52,53 -> no errors, lock only after 53.
- Locked stream 253,254,255,0,1 with in_valid gaps of 3 cycles between samples -> no error_pulse, locked stays 1, expected=2, and all outputs hold during gaps.
- Locked with expected=20, feed 50 then 21 -> one error_pulse, error_count=1, locked stays 1 throughout, expected=22 afterwards.
- Locked with expected=30, feed 99 then 98 -> two error_pulses, error_count=2, locked=0 after 98. Then 5,6,7,8 -> relock with expected=9 and error_count still 2.
- Force error_count to 16'hFFFE, then inject 3 locked mismatches spaced by matches -> count stops at 16'hFFFF, each mismatch pulses. Assert clear_errors on the same edge as a mismatch -> error_count=1.
- While locked, assert rst between clock edges -> locked, error_pulse, expected and error_count read 0 before the next edge. Release rst and feed 0,1,2,3 -> relocks normally.
